// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
// Optional statistics counters are enabled with the FETCH_STATS_EN macro.
package fetch_pkg;
   localparam int          WORD_W  = 32;
   localparam logic [31:0] PC_INC  = 32'd4;
   localparam int          ENTRY_W = 2 * WORD_W;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   // One buffered instruction together with the address it came from
   typedef struct packed {
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
      return {addr[WORD_W-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/instr_prefetch_unit_if.sv
// Memory-side and processor-side signals of the prefetch unit.
// FETCH_STATS_EN adds the fetch/discard counter outputs.
interface instr_prefetch_unit_if;
   logic        oMemReq;
   logic [31:0] oMemAddr;
   logic        iMemAck;
   logic [31:0] iMemData;
   logic        iRead;
   logic        oValid;
   logic [31:0] oInstr;
   logic [31:0] oInstrPC;
   logic        iRedirect;
   logic [31:0] iRedirectPC;
`ifdef FETCH_STATS_EN
   logic [15:0] oFetchCount;
   logic [15:0] oDiscardCount;
`endif

   modport master (
      output oMemReq, oMemAddr, oValid, oInstr, oInstrPC,
      input  iMemAck, iMemData, iRead, iRedirect, iRedirectPC
`ifdef FETCH_STATS_EN
      , output oFetchCount, oDiscardCount
`endif
   );

   modport slave (
      input  oMemReq, oMemAddr, oValid, oInstr, oInstrPC,
      output iMemAck, iMemData, iRead, iRedirect, iRedirectPC
`ifdef FETCH_STATS_EN
      , input oFetchCount, oDiscardCount
`endif
   );
endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry instruction buffer with a registered head entry.
// The parent never pushes when full and only pops when non-empty; flush wins.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       iClk,
   input  logic                       iRst,
   input  logic                       push,
   input  fetch_entry_t               push_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic [$clog2(DEPTH):0]     count,
   output fetch_entry_t               head
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_entry_t       mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_reg, wr_ptr_reg, rd_ptr_inc;
   logic [CNT_W-1:0]   count_reg, count_next;
   fetch_entry_t       head_reg, head_next;

   assign rd_ptr_inc = rd_ptr_reg + PTR_W'(1);

   // Storage write; no reset so it can map onto plain RAM
   always_ff @(posedge iClk) begin
      if (push && !flush) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // Next count and next head: the head register always mirrors mem[rd_ptr]
   always_comb begin
      count_next = count_reg;
      head_next  = head_reg;
      if (flush) begin
         count_next = '0;
      end else begin
         count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
         if (pop) begin
            if (count_reg > CNT_W'(1)) begin
               head_next = mem[rd_ptr_inc];
            end else if (push) begin
               head_next = push_data;
            end
         end else if (push && count_reg == '0) begin
            head_next = push_data;
         end
      end
   end

   // Pointer, count and head registers
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
         head_reg   <= '0;
      end else begin
         count_reg <= count_next;
         head_reg  <= head_next;
         if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
         end else begin
            if (pop)  rd_ptr_reg <= rd_ptr_inc;
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
      end
   end

   assign count = count_reg;
   assign head  = head_reg;
endmodule

// File: rtl/instr_prefetch_unit.sv
// Sequential instruction prefetcher: fetch FSM, fetch PC and a fetch_fifo.
// Define FETCH_STATS_EN to add saturating fetch/discard counters.
module instr_prefetch_unit
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                  iClk,
   input  logic                  iRst,
   instr_prefetch_unit_if.master bus
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   fetch_state_t      state_reg, state_next;
   logic [31:0]       fetch_pc_reg, fetch_pc_next;
   logic [31:0]       discard_addr_reg;
   logic              mem_req;
   logic [31:0]       mem_addr;
   logic              fifo_push, fifo_pop;
   logic [CNT_W-1:0]  fifo_count, count_after;
   fetch_entry_t      fifo_head, push_entry;

   // A redirect beats both a coincident ack write and a processor pop
   assign fifo_push  = (state_reg == REQ) && bus.iMemAck && !bus.iRedirect;
   assign fifo_pop   = bus.iRead && (fifo_count != '0) && !bus.iRedirect;
   assign push_entry = '{pc: fetch_pc_reg, instr: bus.iMemData};

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .iClk      (iClk),
      .iRst      (iRst),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .flush     (bus.iRedirect),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   // Next-state, next fetch PC and memory request outputs
   always_comb begin
      state_next    = state_reg;
      fetch_pc_next = fetch_pc_reg;
      mem_req       = 1'b0;
      mem_addr      = fetch_pc_reg;
      count_after   = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
      unique case (state_reg)
         IDLE: begin
            if (bus.iRedirect) begin
               fetch_pc_next = align_word(bus.iRedirectPC);
            end else if (fifo_count < CNT_W'(DEPTH)) begin
               state_next = REQ;
            end
         end
         REQ: begin
            mem_req = 1'b1;
            if (bus.iRedirect) begin
               fetch_pc_next = align_word(bus.iRedirectPC);
               // Coincident ack is simply dropped; otherwise wait out the old fetch
               state_next    = bus.iMemAck ? REQ : DISCARD;
            end else if (bus.iMemAck) begin
               fetch_pc_next = fetch_pc_reg + PC_INC;
               if (count_after >= CNT_W'(DEPTH)) state_next = IDLE;
            end
         end
         DISCARD: begin
            mem_req  = 1'b1;
            mem_addr = discard_addr_reg;
            if (bus.iRedirect) fetch_pc_next = align_word(bus.iRedirectPC);
            // Buffer was flushed on entry, so there is always room to restart
            if (bus.iMemAck) state_next = REQ;
         end
         default: state_next = IDLE;
      endcase
   end

   // State, fetch PC and the address of an abandoned in-flight fetch
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_reg        <= IDLE;
         fetch_pc_reg     <= RESET_PC;
         discard_addr_reg <= '0;
      end else begin
         state_reg    <= state_next;
         fetch_pc_reg <= fetch_pc_next;
         if (state_reg == REQ && bus.iRedirect && !bus.iMemAck) begin
            discard_addr_reg <= fetch_pc_reg;
         end
      end
   end

   assign bus.oMemReq  = mem_req;
   assign bus.oMemAddr = mem_addr;
   assign bus.oValid   = (fifo_count != '0);
   assign bus.oInstr   = fifo_head.instr;
   assign bus.oInstrPC = fifo_head.pc;

`ifdef FETCH_STATS_EN
   logic        drop_ack;
   logic [15:0] fetch_count_reg, discard_count_reg;

   assign drop_ack = bus.iMemAck &&
                     ((state_reg == REQ && bus.iRedirect) || state_reg == DISCARD);

   // Saturating counts of written and dropped acks
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         fetch_count_reg   <= '0;
         discard_count_reg <= '0;
      end else begin
         if (fifo_push && fetch_count_reg != 16'hFFFF) begin
            fetch_count_reg <= fetch_count_reg + 16'd1;
         end
         if (drop_ack && discard_count_reg != 16'hFFFF) begin
            discard_count_reg <= discard_count_reg + 16'd1;
         end
      end
   end

   assign bus.oFetchCount   = fetch_count_reg;
   assign bus.oDiscardCount = discard_count_reg;
`endif
endmodule
